// File: rtl/reg_write_ctrl_pkg.sv
// rtl/reg_write_ctrl_pkg.sv - register map indices, FSM states and address rule
package reg_write_ctrl_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;
  localparam int NUM_R  = 10;
  localparam int NUM_I  = 10;

  // Register indices as 5-bit values so they compare directly against s_addr[7:3]
  localparam logic [4:0] R_LAST        = 5'd9;
  localparam logic [4:0] I_BASE        = 5'd10;
  localparam logic [4:0] I_LAST        = 5'd19;
  localparam logic [4:0] IDX_OP_START  = 5'd20;
  localparam logic [4:0] IDX_INT_MASK  = 5'd21;
  localparam logic [4:0] IDX_INTERRUPT = 5'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A bus address maps to a register only if it is in the low page, 8-byte aligned and in range
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (addr[15:8] == 8'd0) && (addr[2:0] == 3'd0) && (addr[7:3] <= IDX_INTERRUPT);
  endfunction

endpackage

// File: rtl/reg_write_ctrl_op_ctrl_fsm.sv
// rtl/reg_write_ctrl_op_ctrl_fsm.sv - start/run/done sequencer with accept and clear qualifiers
module op_ctrl_fsm
  import reg_write_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_req,
  input  logic clr_req,
  input  logic core_done,
  output logic start_acc,
  output logic done_acc,
  output logic int_clr,
  output logic op_start,
  output logic busy
);

  state_e state;

  // A start is only taken outside RUN, so a start racing core_done in RUN is dropped
  assign start_acc = start_req && (state == ST_IDLE || state == ST_DONE);
  assign done_acc  = core_done && (state == ST_RUN);
  // The interrupt set from core_done has priority over a same-cycle clear
  assign int_clr   = clr_req && !done_acc;

  // State register plus registered op_start pulse and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      op_start <= start_acc;
      busy     <= start_acc || (state == ST_RUN && !core_done);
      case (state)
        ST_IDLE: if (start_acc) state <= ST_RUN;
        ST_RUN:  if (core_done) state <= ST_DONE;
        ST_DONE: begin
          if (start_acc)    state <= ST_RUN;
          else if (clr_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// rtl/reg_write_ctrl.sv - write-side register file, address decode and operation control
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  input  logic              res_we,
  input  logic [3:0]        res_idx,
  input  logic [DATA_W-1:0] res_data,
  input  logic              core_done,
  output logic              op_start,
  output logic              busy,
  output logic              irq,
  output logic [DATA_W-1:0] from_reg0,
  output logic [DATA_W-1:0] from_reg1,
  output logic [DATA_W-1:0] from_reg2,
  output logic [DATA_W-1:0] from_reg3,
  output logic [DATA_W-1:0] from_reg4,
  output logic [DATA_W-1:0] from_reg5,
  output logic [DATA_W-1:0] from_reg6,
  output logic [DATA_W-1:0] from_reg7,
  output logic [DATA_W-1:0] from_reg8,
  output logic [DATA_W-1:0] from_reg9,
  output logic [DATA_W-1:0] from_reg10,
  output logic [DATA_W-1:0] from_reg11,
  output logic [DATA_W-1:0] from_reg12,
  output logic [DATA_W-1:0] from_reg13,
  output logic [DATA_W-1:0] from_reg14,
  output logic [DATA_W-1:0] from_reg15,
  output logic [DATA_W-1:0] from_reg16,
  output logic [DATA_W-1:0] from_reg17,
  output logic [DATA_W-1:0] from_reg18,
  output logic [DATA_W-1:0] from_reg19,
  output logic [DATA_W-1:0] from_reg20,
  output logic [DATA_W-1:0] from_reg21,
  output logic [DATA_W-1:0] from_reg22
);

  // Result (0..9) and operand (10..19) registers share one array; control bits live apart
  logic [DATA_W-1:0] data_q [0:NUM_R+NUM_I-1];
  logic              op_start_bit;
  logic              int_mask_bit;
  logic              int_bit;

  logic       bus_wr;
  logic [4:0] wr_idx;
  logic       start_acc;
  logic       done_acc;
  logic       int_clr;

  assign wr_idx = s_addr[7:3];
  assign bus_wr = s_sel && s_wr && addr_valid(s_addr);

  op_ctrl_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .start_req (bus_wr && wr_idx == IDX_OP_START && s_din[0]),
    .clr_req   (bus_wr && wr_idx == IDX_INTERRUPT && s_din[0]),
    .core_done (core_done),
    .start_acc (start_acc),
    .done_acc  (done_acc),
    .int_clr   (int_clr),
    .op_start  (op_start),
    .busy      (busy)
  );

  // Core writes results, bus writes operands; the index ranges never overlap
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_R + NUM_I; i++) data_q[i] <= '0;
    end else begin
      if (res_we && {1'b0, res_idx} <= R_LAST) data_q[{1'b0, res_idx}] <= res_data;
      if (bus_wr && wr_idx >= I_BASE && wr_idx <= I_LAST) data_q[wr_idx] <= s_din;
    end
  end

  // Control bits: mask is plain storage, start/interrupt follow the FSM qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_start_bit <= 1'b0;
      int_mask_bit <= 1'b0;
      int_bit      <= 1'b0;
    end else begin
      if (bus_wr && wr_idx == IDX_INT_MASK) int_mask_bit <= s_din[0];
      if (done_acc) begin
        int_bit      <= 1'b1;
        op_start_bit <= 1'b0;
      end else if (start_acc) begin
        op_start_bit <= 1'b1;
        int_bit      <= 1'b0;
      end else if (int_clr) begin
        int_bit      <= 1'b0;
      end
    end
  end

  assign irq = int_bit && int_mask_bit;

  assign from_reg0  = data_q[0];
  assign from_reg1  = data_q[1];
  assign from_reg2  = data_q[2];
  assign from_reg3  = data_q[3];
  assign from_reg4  = data_q[4];
  assign from_reg5  = data_q[5];
  assign from_reg6  = data_q[6];
  assign from_reg7  = data_q[7];
  assign from_reg8  = data_q[8];
  assign from_reg9  = data_q[9];
  assign from_reg10 = data_q[10];
  assign from_reg11 = data_q[11];
  assign from_reg12 = data_q[12];
  assign from_reg13 = data_q[13];
  assign from_reg14 = data_q[14];
  assign from_reg15 = data_q[15];
  assign from_reg16 = data_q[16];
  assign from_reg17 = data_q[17];
  assign from_reg18 = data_q[18];
  assign from_reg19 = data_q[19];
  assign from_reg20 = {{(DATA_W-1){1'b0}}, op_start_bit};
  assign from_reg21 = {{(DATA_W-1){1'b0}}, int_mask_bit};
  assign from_reg22 = {{(DATA_W-1){1'b0}}, int_bit};

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb/tb_reg_write_ctrl.sv - vector table, corner sequences and randomized model comparison
module tb_reg_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_sel, s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic        res_we;
  logic [3:0]  res_idx;
  logic [63:0] res_data;
  logic        core_done;
  logic        op_start, busy, irq;
  logic [63:0] fr [0:22];

  int checks = 0;
  int errors = 0;

  // Reference model: 23 register values, state 0=IDLE 1=RUN 2=DONE, expected op_start pulse
  logic [63:0] m_reg [0:22];
  int          m_st;
  logic        m_op;

  always #5 clk = ~clk;

  reg_write_ctrl dut (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .res_we(res_we), .res_idx(res_idx), .res_data(res_data), .core_done(core_done),
    .op_start(op_start), .busy(busy), .irq(irq),
    .from_reg0(fr[0]),   .from_reg1(fr[1]),   .from_reg2(fr[2]),   .from_reg3(fr[3]),
    .from_reg4(fr[4]),   .from_reg5(fr[5]),   .from_reg6(fr[6]),   .from_reg7(fr[7]),
    .from_reg8(fr[8]),   .from_reg9(fr[9]),   .from_reg10(fr[10]), .from_reg11(fr[11]),
    .from_reg12(fr[12]), .from_reg13(fr[13]), .from_reg14(fr[14]), .from_reg15(fr[15]),
    .from_reg16(fr[16]), .from_reg17(fr[17]), .from_reg18(fr[18]), .from_reg19(fr[19]),
    .from_reg20(fr[20]), .from_reg21(fr[21]), .from_reg22(fr[22])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the register-map rules, compare everything
  task automatic step(input logic rst, input logic sel, input logic wr, input logic [15:0] addr,
                      input logic [63:0] din, input logic rwe, input logic [3:0] ridx,
                      input logic [63:0] rdata, input logic done);
    logic [63:0] n [0:22];
    int   st;
    logic op;
    logic valid;
    int   idx;
    reset = rst; s_sel = sel; s_wr = wr; s_addr = addr; s_din = din;
    res_we = rwe; res_idx = ridx; res_data = rdata; core_done = done;
    n = m_reg; st = m_st; op = 1'b0;
    idx = int'(addr[7:3]);
    valid = sel && wr && addr[15:8] == 8'd0 && addr[2:0] == 3'd0 && idx <= 22;
    if (rst) begin
      for (int i = 0; i < 23; i++) n[i] = 64'd0;
      st = 0;
    end else begin
      if (rwe && ridx <= 4'd9) n[ridx] = rdata;
      if (valid && idx >= 10 && idx <= 19) n[idx] = din;
      if (valid && idx == 21) n[21] = {63'd0, din[0]};
      if (done && st == 1) begin
        n[22] = 64'd1; n[20] = 64'd0; st = 2;
      end else if (valid && idx == 20 && din[0] && st != 1) begin
        n[20] = 64'd1; n[22] = 64'd0; st = 1; op = 1'b1;
      end else if (valid && idx == 22 && din[0]) begin
        n[22] = 64'd0;
        if (st == 2) st = 0;
      end
    end
    @(posedge clk);
    #1;
    m_reg = n; m_st = st; m_op = op;
    for (int i = 0; i < 23; i++) chk($sformatf("model_from_reg%0d", i), fr[i], m_reg[i]);
    chk("model_op_start", 64'(op_start), 64'(m_op));
    chk("model_busy", 64'(busy), 64'(m_st == 1));
    chk("model_irq", 64'(irq), 64'(m_reg[22][0] & m_reg[21][0]));
  endtask

  typedef struct {
    logic        sel;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] din;
    logic        rwe;
    logic [3:0]  ridx;
    logic [63:0] rdata;
    logic        done;
    int          reg_idx;
    logic [63:0] exp_val;
    logic        exp_op;
    logic        exp_busy;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 23; i++) m_reg[i] = 64'd0;
    m_st = 0;
    m_op = 1'b0;

    // Reset state
    step(1, 0, 0, 16'd0, 64'd0, 0, 4'd0, 64'd0, 0);
    step(1, 0, 0, 16'd0, 64'd0, 0, 4'd0, 64'd0, 0);
    for (int i = 0; i < 23; i++) chk($sformatf("reset_from_reg%0d", i), fr[i], 64'd0);
    chk("reset_op_start", 64'(op_start), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_irq", 64'(irq), 64'd0);

    //            sel wr addr      din                    rwe ridx   rdata                  done reg exp                   op busy irq
    tbl.push_back('{1, 1, 16'h0018, 64'hDEAD,              0, 4'd0,  64'd0,                 0,   3,  64'd0,                0, 0, 0});
    tbl.push_back('{1, 1, 16'h0050, 64'h1234,              0, 4'd0,  64'd0,                 0,   10, 64'h1234,             0, 0, 0});
    tbl.push_back('{1, 1, 16'h00A8, 64'd1,                 0, 4'd0,  64'd0,                 0,   21, 64'd1,                0, 0, 0});
    tbl.push_back('{1, 1, 16'h00A0, 64'd1,                 0, 4'd0,  64'd0,                 0,   20, 64'd1,                1, 1, 0});
    tbl.push_back('{0, 0, 16'h0000, 64'd0,                 0, 4'd0,  64'd0,                 0,   20, 64'd1,                0, 1, 0});
    tbl.push_back('{0, 0, 16'h0000, 64'd0,                 0, 4'd0,  64'd0,                 1,   22, 64'd1,                0, 0, 1});
    tbl.push_back('{0, 0, 16'h0000, 64'd0,                 0, 4'd0,  64'd0,                 0,   20, 64'd0,                0, 0, 1});
    tbl.push_back('{0, 0, 16'h0000, 64'd0,                 1, 4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 0, 9,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1});
    tbl.push_back('{0, 0, 16'h0000, 64'd0,                 1, 4'd12, 64'd5,                 0,   12, 64'd0,                0, 0, 1});
    tbl.push_back('{1, 1, 16'h00B0, 64'd0,                 0, 4'd0,  64'd0,                 0,   22, 64'd1,                0, 0, 1});
    tbl.push_back('{1, 1, 16'h00B0, 64'd1,                 0, 4'd0,  64'd0,                 0,   22, 64'd0,                0, 0, 0});
    tbl.push_back('{1, 1, 16'h00A0, 64'd1,                 0, 4'd0,  64'd0,                 0,   20, 64'd1,                1, 1, 0});
    tbl.push_back('{1, 1, 16'h00A0, 64'd1,                 0, 4'd0,  64'd0,                 1,   22, 64'd1,                0, 0, 1});
    tbl.push_back('{1, 1, 16'h00A0, 64'd3,                 0, 4'd0,  64'd0,                 0,   22, 64'd0,                1, 1, 0});
    tbl.push_back('{1, 1, 16'h00B0, 64'd1,                 0, 4'd0,  64'd0,                 1,   22, 64'd1,                0, 0, 1});
    tbl.push_back('{1, 1, 16'h00B0, 64'd1,                 0, 4'd0,  64'd0,                 0,   22, 64'd0,                0, 0, 0});
    tbl.push_back('{1, 1, 16'h00A0, 64'd2,                 0, 4'd0,  64'd0,                 0,   20, 64'd0,                0, 0, 0});
    tbl.push_back('{1, 1, 16'h0051, 64'd77,                0, 4'd0,  64'd0,                 0,   10, 64'h1234,             0, 0, 0});
    tbl.push_back('{1, 1, 16'h01A0, 64'd1,                 0, 4'd0,  64'd0,                 0,   20, 64'd0,                0, 0, 0});
    tbl.push_back('{1, 1, 16'h0150, 64'd99,                0, 4'd0,  64'd0,                 0,   10, 64'h1234,             0, 0, 0});
    tbl.push_back('{1, 1, 16'h00B8, 64'd1,                 0, 4'd0,  64'd0,                 0,   22, 64'd0,                0, 0, 0});
    tbl.push_back('{1, 0, 16'h0050, 64'd9,                 0, 4'd0,  64'd0,                 0,   10, 64'h1234,             0, 0, 0});
    tbl.push_back('{1, 1, 16'h00A8, 64'd0,                 0, 4'd0,  64'd0,                 0,   21, 64'd0,                0, 0, 0});

    foreach (tbl[i]) begin
      step(0, tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].rwe, tbl[i].ridx,
           tbl[i].rdata, tbl[i].done);
      chk($sformatf("vec%0d_from_reg%0d", i, tbl[i].reg_idx), fr[tbl[i].reg_idx], tbl[i].exp_val);
      chk($sformatf("vec%0d_op_start", i), 64'(op_start), 64'(tbl[i].exp_op));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_irq", i), 64'(irq), 64'(tbl[i].exp_irq));
    end

    // Reset mid-RUN aborts the operation; a later core_done must not raise INTERRUPT
    step(0, 1, 1, 16'h00A0, 64'd1, 0, 4'd0, 64'd0, 0);
    chk("abort_busy_before", 64'(busy), 64'd1);
    step(1, 0, 0, 16'h0000, 64'd0, 0, 4'd0, 64'd0, 0);
    chk("abort_busy_reset", 64'(busy), 64'd0);
    step(0, 0, 0, 16'h0000, 64'd0, 0, 4'd0, 64'd0, 1);
    chk("abort_interrupt", fr[22], 64'd0);
    chk("abort_op_start_reg", fr[20], 64'd0);
    chk("abort_busy_after", 64'(busy), 64'd0);

    // Result write and core_done in the same cycle both land
    step(0, 1, 1, 16'h00A0, 64'd1, 0, 4'd0, 64'd0, 0);
    step(0, 0, 0, 16'h0000, 64'd0, 1, 4'd0, 64'hA5A5_0000_0000_5A5A, 1);
    chk("res_done_reg0", fr[0], 64'hA5A5_0000_0000_5A5A);
    chk("res_done_interrupt", fr[22], 64'd1);

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] a;
      logic [63:0] d;
      a = {8'd0, 5'($urandom_range(0, 24)), 3'd0};
      if ($urandom_range(0, 9) == 0) a = 16'($urandom);
      d = {32'($urandom), 32'($urandom)};
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), a, d, 1'($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)), {32'($urandom), 32'($urandom)},
           1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
